// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: Q16.16 element type and ReLU.
// Also used by the dense layers and the neuron MACs.
package nn_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;

    typedef logic signed [DATA_W-1:0] data_t;

    // A set sign bit means negative, so the result is clamped to zero.
    function automatic data_t relu(input data_t d);
        return d[DATA_W-1] ? '0 : d;
    endfunction

endpackage

// File: rtl/dense_relu_streamer_if.sv
// Handshake bundle of the dense-layer output stage: vector capture, beat stream, argmax report.
// The master modport is the surrounding logic; the slave modport is the streamer itself.
interface dense_relu_streamer_if #(
    parameter int ROWS  = 8,
    parameter int IDX_W = $clog2(ROWS)
);
    import nn_pkg::*;

    logic             in_valid;
    logic             in_ready;
    data_t            in_layer [ROWS-1:0];
    logic             out_valid;
    logic             out_ready;
    data_t            out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             argmax_valid;
    logic [IDX_W-1:0] argmax_idx;

    modport master (
        output in_valid, in_layer, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, argmax_valid, argmax_idx
    );

    modport slave (
        input  in_valid, in_layer, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, argmax_valid, argmax_idx
    );

endinterface

// File: rtl/relu_argmax_step.sv
// One combinational step of a running argmax over ReLU'd elements.
// Strict compare, so ties keep the earlier (lower) index. Also reused by the pooling stage.
module relu_argmax_step
    import nn_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  data_t            cur_max,
    input  logic [IDX_W-1:0] cur_idx,
    input  data_t            data,
    input  logic [IDX_W-1:0] index,
    output data_t            new_max,
    output logic [IDX_W-1:0] new_idx
);

    data_t act;

    assign act = relu(data);

    always_comb begin
        // NOTE: defaults first, so no path leaves an output unassigned and infers a latch.
        new_max = cur_max;
        new_idx = cur_idx;
        if (act > cur_max) begin
            new_max = act;
            new_idx = index;
        end
    end

endmodule

// File: rtl/dense_relu_streamer.sv
// Captures one dense-layer result vector, streams ReLU(element) one beat at a time,
// then pulses the argmax index of the streamed elements for one cycle.
module dense_relu_streamer
    import nn_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int IDX_W = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    dense_relu_streamer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

    state_t           state;
    state_t           state_nxt;
    data_t            buffer [ROWS-1:0];
    logic [IDX_W-1:0] cnt;
    data_t            max_val;
    logic [IDX_W-1:0] max_idx;
    data_t            step_max;
    logic [IDX_W-1:0] step_idx;
    logic [IDX_W-1:0] argmax_q;
    logic             capture;
    logic             beat;

    assign capture = (state == IDLE) && bus.in_valid;
    assign beat    = (state == STREAM) && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.in_ready     = 1'b0;
        bus.out_valid    = 1'b0;
        bus.argmax_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = STREAM;
            end
            STREAM: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && (cnt == LAST)) state_nxt = REPORT;
            end
            REPORT: begin
                bus.argmax_valid = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    relu_argmax_step #(.IDX_W(IDX_W)) u_step (
        .cur_max (max_val),
        .cur_idx (max_idx),
        .data    (buffer[cnt]),
        .index   (cnt),
        .new_max (step_max),
        .new_idx (step_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is cleared on reset because out_data reads it directly and must be 0.
            for (int i = 0; i < ROWS; i++) buffer[i] <= '0;
            cnt      <= '0;
            max_val  <= '0;
            max_idx  <= '0;
            argmax_q <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < ROWS; i++) buffer[i] <= relu(bus.in_layer[i]);
                cnt     <= '0;
                max_val <= '0;
                max_idx <= '0;
            end
            if (beat) begin
                max_val <= step_max;
                max_idx <= step_idx;
                if (cnt == LAST) begin
                    cnt      <= '0;
                    argmax_q <= step_idx;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end
        end
    end

    assign bus.out_data   = buffer[cnt];
    assign bus.out_index  = cnt;
    assign bus.out_last   = (state == STREAM) && (cnt == LAST);
    assign bus.argmax_idx = argmax_q;

endmodule

// File: tb/tb_dense_relu_streamer.sv
// Randomised scoreboard bench for dense_relu_streamer: stimulus pushes expected beats and
// argmax from a plain reference model; an independent monitor pops and compares.
module tb_dense_relu_streamer;
    import nn_pkg::*;

    localparam int ROWS  = 8;
    localparam int IDX_W = $clog2(ROWS);

    typedef data_t vec_t [ROWS-1:0];
    typedef struct {
        data_t            data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dense_relu_streamer_if #(.ROWS(ROWS)) bus ();

    dense_relu_streamer #(.ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               checks = 0;
    int               errors = 0;
    beat_t            exp_beats [$];
    logic [IDX_W-1:0] exp_args  [$];
    int unsigned      cyc      = 0;
    int unsigned      last_cap = 0;
    int               rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (event not expected or bound expired)", name);
    endtask

    // Reference model: element-wise max(x, 0) and first index of the largest value (floor 0 at index 0).
    function automatic data_t ref_relu(input data_t x);
        return (x < 0) ? data_t'(0) : x;
    endfunction

    task automatic push_expected(input vec_t v);
        data_t best   = 0;
        int    best_i = 0;
        beat_t b;
        for (int i = 0; i < ROWS; i++) begin
            b.data = ref_relu(v[i]);
            b.idx  = IDX_W'(i);
            b.last = (i == ROWS - 1);
            exp_beats.push_back(b);
            if (b.data > best) begin
                best   = b.data;
                best_i = i;
            end
        end
        exp_args.push_back(IDX_W'(best_i));
    endtask

    function automatic data_t rand_elem();
        case ($urandom_range(0, 4))
            0:       return data_t'($urandom);
            1:       return data_t'($urandom_range(0, 3) * 65536);
            2:       return -data_t'($urandom_range(1, 4 * 65536));
            3:       return data_t'(32'h7FFF_FFFF);
            default: return data_t'(32'h8000_0000);
        endcase
    endfunction

    task automatic send_vector(input vec_t v, input bit hold_valid);
        int waited = 0;
        @(posedge clk);
        #1;
        bus.in_layer = v;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                fail("capture_timeout");
                bus.in_valid = 1'b0;
                return;
            end
        end
        push_expected(v);
        last_cap = cyc;
        @(posedge clk);
        #1;
        if (!hold_valid) bus.in_valid = 1'b0;
        @(negedge clk);
        check("first_beat_valid", bus.out_valid, 1);
        check("first_beat_index", bus.out_index, 0);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_beats.size() != 0 || exp_args.size() != 0) begin
            @(negedge clk);
            waited++;
            if (waited > 2000) begin
                fail("drain_timeout");
                exp_beats.delete();
                exp_args.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
    initial begin
        int phase = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (phase == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            phase = (phase == 2) ? 0 : phase + 1;
        end
    end

    // Monitor: decoupled from stimulus, compares whatever the DUT presents against the queues.
    bit               was_stalled = 1'b0;
    bit               arg_due     = 1'b0;
    bit               arg_hold    = 1'b0;
    logic [IDX_W-1:0] last_arg    = '0;
    logic [IDX_W-1:0] exp_arg;
    beat_t            e;

    always @(negedge clk) begin
        if (rst) begin
            was_stalled = 1'b0;
            arg_due     = 1'b0;
            arg_hold    = 1'b0;
        end else begin
            if (bus.out_valid || bus.argmax_valid) check("in_ready_while_busy", bus.in_ready, 0);
            if (arg_due) begin
                check("argmax_pulse_timing", bus.argmax_valid, 1);
                arg_due = 1'b0;
            end
            if (bus.argmax_valid) begin
                if (exp_args.size() == 0) begin
                    fail("argmax_unexpected");
                end else begin
                    exp_arg = exp_args.pop_front();
                    check("argmax_idx", bus.argmax_idx, exp_arg);
                    last_arg = exp_arg;
                    arg_hold = 1'b1;
                end
            end else if (arg_hold) begin
                check("argmax_idx_hold", bus.argmax_idx, last_arg);
                arg_hold = 1'b0;
            end
            if (was_stalled) check("stall_valid_kept", bus.out_valid, 1);
            was_stalled = 1'b0;
            if (bus.out_valid) begin
                if (exp_beats.size() == 0) begin
                    fail("beat_unexpected");
                end else if (bus.out_ready) begin
                    e = exp_beats.pop_front();
                    check("beat_data", bus.out_data, e.data);
                    check("beat_index", bus.out_index, e.idx);
                    check("beat_last", bus.out_last, e.last);
                    if (e.last) arg_due = 1'b1;
                end else begin
                    check("stall_data", bus.out_data, exp_beats[0].data);
                    check("stall_index", bus.out_index, exp_beats[0].idx);
                    check("stall_last", bus.out_last, exp_beats[0].last);
                    was_stalled = 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t        v;
        int unsigned prev_cap;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < ROWS; i++) bus.in_layer[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_out_index", bus.out_index, 0);
        check("reset_out_last", bus.out_last, 0);
        check("reset_argmax_valid", bus.argmax_valid, 0);
        check("reset_argmax_idx", bus.argmax_idx, 0);

        // Known vector, always ready.
        v[0] = 32'sh0001_0000;
        v[1] = 32'shFFFE_0000;
        v[2] = 32'sh0003_8000;
        v[3] = 32'sh0000_0000;
        v[4] = 32'shFFFF_8000;
        v[5] = 32'sh0002_0000;
        v[6] = 32'sh0007_4000;
        v[7] = 32'sh0001_0000;
        rdy_mode = 0;
        send_vector(v, 1'b0);
        drain();

        // Same vector under 1,0,0 backpressure.
        rdy_mode = 1;
        send_vector(v, 1'b0);
        drain();

        // All negative, then all equal.
        rdy_mode = 0;
        for (int i = 0; i < ROWS; i++) v[i] = 32'shFFFF_0000;
        send_vector(v, 1'b0);
        drain();
        for (int i = 0; i < ROWS; i++) v[i] = 32'sh0005_0000;
        send_vector(v, 1'b0);
        drain();

        // Back-to-back with in_valid held high: next capture exactly ROWS+2 cycles later.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ROWS; i++) v[i] = rand_elem();
            prev_cap = last_cap;
            send_vector(v, k < 2);
            if (k > 0) check("b2b_capture_gap", last_cap - prev_cap, ROWS + 2);
        end
        drain();

        // in_valid pulse with different data mid-stream must not disturb the buffer.
        rdy_mode = 1;
        for (int i = 0; i < ROWS; i++) v[i] = rand_elem();
        send_vector(v, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < ROWS; i++) bus.in_layer[i] = 32'sh7FFF_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Randomised vectors with random backpressure and random back-to-back.
        rdy_mode = 2;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < ROWS; i++) v[i] = rand_elem();
            send_vector(v, (k < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        drain();

        // Mid-stream reset aborts the vector and emits no argmax.
        rdy_mode = 0;
        for (int i = 0; i < ROWS; i++) v[i] = rand_elem();
        send_vector(v, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_beats.delete();
        exp_args.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_argmax_valid", bus.argmax_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_argmax_idx", bus.argmax_idx, 0);
        repeat (ROWS + 2) @(negedge clk);

        // Recovery after reset.
        for (int i = 0; i < ROWS; i++) v[i] = rand_elem();
        send_vector(v, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
